// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RISC-V core: decoded control bundle,
// its all-zero bubble encoding and default datapath widths.
package core_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;
    localparam int FUNCT_W  = 10;   // {funct7, funct3}

    typedef struct packed {
        logic       jalr;
        logic       jal;
        logic       branch;
        logic       MemRead;
        logic       MemtoReg;
        logic [1:0] ALUOp;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegWrite;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = ctrl_t'(10'b00_0000_0000);

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async clear, synchronous clear that
// wins over load enable, otherwise holds.
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Field storage: reset > synchronous clear > load > hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= {W{1'b0}};
        end else if (clr_i) begin
            q_q <= {W{1'b0}};
        end else if (en_i) begin
            q_q <= d_i;
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control and operands, supports
// hold, squash to bubble, and counts injected bubbles (saturating).
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic                 jalr_i,
    input  logic                 jal_i,
    input  logic                 branch_i,
    input  logic                 MemRead_i,
    input  logic                 MemtoReg_i,
    input  logic                 MemWrite_i,
    input  logic                 ALUSrc_i,
    input  logic                 RegWrite_i,
    input  logic [1:0]           ALUOp_i,
    input  logic [FUNCT_W-1:0]   funct_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [RA_W-1:0]      rs1_addr_i,
    input  logic [RA_W-1:0]      rs2_addr_i,
    input  logic [RA_W-1:0]      rd_addr_i,
    output logic                 valid_o,
    output logic                 jalr_o,
    output logic                 jal_o,
    output logic                 branch_o,
    output logic                 MemRead_o,
    output logic                 MemtoReg_o,
    output logic                 MemWrite_o,
    output logic                 ALUSrc_o,
    output logic                 RegWrite_o,
    output logic [1:0]           ALUOp_o,
    output logic [FUNCT_W-1:0]   funct_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [RA_W-1:0]      rs1_addr_o,
    output logic [RA_W-1:0]      rs2_addr_o,
    output logic [RA_W-1:0]      rd_addr_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    localparam int CB_W = CTRL_W + 1;
    localparam int DB_W = FUNCT_W + 4 * XLEN + 3 * RA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t             ctrl_in_s;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;
    logic              valid_q;
    logic [CB_W-1:0]   cbus_q;
    logic [DB_W-1:0]   dbus_d;
    logic [DB_W-1:0]   dbus_q;
    logic              load_s;
    logic              bubble_s;
    logic              cnt_inc_s;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_q;

    // start_i low freezes everything; flush beats stall.
    assign load_s    = start_i & ~flush_i & ~stall_i;
    assign bubble_s  = start_i & flush_i;
    assign cnt_inc_s = bubble_s | (load_s & ~valid_i);

    assign ctrl_in_s = '{jalr: jalr_i, jal: jal_i, branch: branch_i,
                         MemRead: MemRead_i, MemtoReg: MemtoReg_i,
                         ALUOp: ALUOp_i, MemWrite: MemWrite_i,
                         ALUSrc: ALUSrc_i, RegWrite: RegWrite_i};

    // A decode NoOp enters EX with every control bit cleared.
    always_comb begin
        ctrl_d = CTRL_NOP;
        if (valid_i) begin
            ctrl_d = ctrl_in_s;
        end else begin
            ctrl_d = CTRL_NOP;
        end
    end

    assign dbus_d = {funct_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
                     rs1_addr_i, rs2_addr_i, rd_addr_i};

    pipe_field_reg #(.W(CB_W)) u_ctrl_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (load_s),
        .clr_i (bubble_s),
        .d_i   ({valid_i, ctrl_d}),
        .q_o   (cbus_q)
    );

    pipe_field_reg #(.W(DB_W)) u_data_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (load_s),
        .clr_i (bubble_s),
        .d_i   (dbus_d),
        .q_o   (dbus_q)
    );

    assign {valid_q, ctrl_q} = cbus_q;

    // Saturating bubble counter next state.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Bubble counter storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign jalr_o       = ctrl_q.jalr;
    assign jal_o        = ctrl_q.jal;
    assign branch_o     = ctrl_q.branch;
    assign MemRead_o    = ctrl_q.MemRead;
    assign MemtoReg_o   = ctrl_q.MemtoReg;
    assign ALUOp_o      = ctrl_q.ALUOp;
    assign MemWrite_o   = ctrl_q.MemWrite;
    assign ALUSrc_o     = ctrl_q.ALUSrc;
    assign RegWrite_o   = ctrl_q.RegWrite;
    assign {funct_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
            rs1_addr_o, rs2_addr_o, rd_addr_o} = dbus_q;
    assign bubble_cnt_o = cnt_q;

endmodule
